// File: rtl/fnd_scan_controller.sv
// Four-digit FND scan controller: time-multiplexes a 16-bit nibble word onto one digit at a time,
// with inter-digit blank gaps, frame-synchronous word updates and optional leading-zero blanking.
module fnd_scan_controller #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic        i_load,
    input  logic        i_lz_blank,
    output logic [1:0]  o_digitSelect,
    output logic        o_digit_en,
    output logic [3:0]  o_value,
    output logic        o_dp,
    output logic        o_frame_done
);
    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t        state, nstate;
    logic [1:0]    digit, ndigit;
    logic [CW-1:0] cnt, ncnt;
    logic [15:0]   act_val, pend_val, nact_val;
    logic [3:0]    act_dp, pend_dp, nact_dp;
    logic          pend_vld, xfer, blanked, lit;
    logic [3:0]    nib;

    always_comb begin
        nstate = state;
        ndigit = digit;
        ncnt   = cnt;
        if (!i_en) begin
            nstate = IDLE;
            ndigit = 2'd0;
            ncnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    nstate = SHOW;
                    ndigit = 2'd0;
                    ncnt   = '0;
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        ncnt = '0;
                        if (BLANK_CYCLES == 0) ndigit = digit + 2'd1;
                        else                   nstate = BLANK;
                    end else begin
                        ncnt = cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt == BLANK_LAST) begin
                        nstate = SHOW;
                        ndigit = digit + 2'd1;
                        ncnt   = '0;
                    end else begin
                        ncnt = cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // New words only land on the edge that starts a frame (or while idle), so a frame never tears.
    always_comb begin
        xfer     = (state == IDLE) || (nstate == SHOW && ndigit == 2'd0 && digit == 2'd3);
        nact_val = act_val;
        nact_dp  = act_dp;
        if (xfer) begin
            if (i_load) begin
                nact_val = i_value;
                nact_dp  = i_dp;
            end else if (pend_vld) begin
                nact_val = pend_val;
                nact_dp  = pend_dp;
            end
        end
    end

    always_comb begin
        case (ndigit)
            2'd0: begin blanked = 1'b0;                  nib = nact_val[3:0];   end
            2'd1: begin blanked = (nact_val[15:4] == '0); nib = nact_val[7:4];   end
            2'd2: begin blanked = (nact_val[15:8] == '0); nib = nact_val[11:8];  end
            default: begin blanked = (nact_val[15:12] == '0); nib = nact_val[15:12]; end
        endcase
        lit = (nstate == SHOW) && !(i_lz_blank && blanked);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            digit         <= 2'd0;
            cnt           <= '0;
            act_val       <= '0;
            act_dp        <= '0;
            pend_val      <= '0;
            pend_dp       <= '0;
            pend_vld      <= 1'b0;
            o_digitSelect <= 2'd0;
            o_digit_en    <= 1'b0;
            o_value       <= 4'd0;
            o_dp          <= 1'b0;
            o_frame_done  <= 1'b0;
        end else begin
            state   <= nstate;
            digit   <= ndigit;
            cnt     <= ncnt;
            act_val <= nact_val;
            act_dp  <= nact_dp;
            if (xfer) begin
                pend_vld <= 1'b0;
            end else if (i_load) begin
                pend_val <= i_value;
                pend_dp  <= i_dp;
                pend_vld <= 1'b1;
            end
            o_digitSelect <= ndigit;
            o_digit_en    <= lit;
            o_value       <= (nstate == IDLE) ? 4'd0 : nib;
            o_dp          <= lit & nact_dp[ndigit];
            o_frame_done  <= (nstate == SHOW) && (ndigit == 2'd3) && (ncnt == SHOW_LAST);
        end
    end
endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Time-multiplexing scan controller for the 4-digit FND display. It holds a 16-bit, four-nibble display word and cycles through the digits, one at a time. For each digit it drives the digit-select decoder (o_digitSelect), the shared decoder enable (o_digit_en) and the font decoder input (o_value). It adds an anti-ghosting blank gap between digits, tear-free frame-synchronous updates and optional leading-zero blanking.

Parameters:
CLK_DIV, 100000, i_clk cycles each digit is shown (SHOW length); legal range >= 2.
BLANK_CYCLES, 2, cycles with o_digit_en=0 between digits; 0 means no BLANK state.

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_en  input  1  display enable; 0 forces IDLE
i_value  input  16  display word; nibble k (i_value[4k+3:4k]) goes to digit k; digit 3 is most significant
i_dp  input  4  decimal point per digit; bit k belongs to digit k
i_load  input  1  1-cycle strobe; captures i_value/i_dp into the pending register
i_lz_blank  input  1  1 = blank leading-zero digits
o_digitSelect  output  2  active digit index, to the digit-select decoder
o_digit_en  output  1  enable to both decoders; 0 = all digits dark
o_value  output  4  nibble for the active digit, to the font decoder
o_dp  output  1  decimal point for the active digit
o_frame_done  output  1  1-cycle pulse on the last SHOW cycle of digit 3

Behaviour:
- Reset state: state=IDLE, o_digitSelect=0, o_digit_en=0, o_value=0, o_dp=0, o_frame_done=0, counter=0, active/pending registers=0, pending_valid=0. Reset takes priority over all other inputs, including mid-scan.
- All outputs are registered. o_value, o_dp and o_digit_en change on the same edge as o_digitSelect; they are never skewed.
- States:
  - IDLE: outputs dark, o_digitSelect=0. If i_en=1, next state is SHOW with digit 0 and counter=0.
  - SHOW: o_digit_en=1 unless the digit is blanked. Counter counts 0..CLK_DIV-1. At CLK_DIV-1 the next state is BLANK, or SHOW of the next digit if BLANK_CYCLES=0.
  - BLANK: o_digit_en=0 and o_digitSelect holds the old digit. Lasts BLANK_CYCLES cycles; then o_digitSelect=(d+1) mod 4 (wrap 3->0), state=SHOW, counter=0.
- i_en=0 in any state: IDLE on the next edge, counter cleared, o_digitSelect=0. Re-enabling always restarts at digit 0 with a full CLK_DIV period.
- Frame period = 4*(CLK_DIV+BLANK_CYCLES) cycles.
- o_frame_done is high exactly during the cycle where state=SHOW, digit=3 and counter=CLK_DIV-1.
- Load and update:
  - i_load=1 writes i_value/i_dp to the pending register and sets pending_valid.
  - Pending data transfers to the active register only at a frame boundary (the edge entering SHOW digit 0), or on any edge while in IDLE. pending_valid then clears.
  - If i_load coincides with a boundary or IDLE edge, i_value/i_dp go straight into active and pending_valid stays 0.
  - A later i_load overwrites pending; the last value before the boundary wins.
  - The displayed frame never mixes old and new words.
- Leading-zero blank (i_lz_blank=1): digit k (k=1..3) is blanked if active nibbles k..3 are all 0. A blanked digit gets o_digit_en=0 and o_dp=0 for its SHOW period, but timing is unchanged. Digit 0 is never blanked. i_lz_blank is sampled combinationally each SHOW cycle.
- Nibbles A-F are passed through unmodified; the font decoder handles them.

Test Plan:
- Reset: assert i_reset for 3 cycles with i_en=1 and i_load=1 -> all outputs 0 and state IDLE throughout; after release, SHOW digit 0 begins on the next edge.
- Scan order (CLK_DIV=4, BLANK_CYCLES=1), load 0x1234 in IDLE, i_en=1 -> sequence is (sel0,val4,en1)x4, en0x1, (sel1,val3)x4, en0x1, (sel2,val2)x4, en0x1, (sel3,val1)x4, en0x1, then sel0 again. Frame = 20 cycles. o_frame_done pulses once, on the 4th sel3 cycle.
- Tear-free update: load 0x5678 during digit 1 of a 0x1234 frame -> digits 2 and 3 still show 2 and 1; the next frame shows 8,7,6,5. Two loads in one frame -> only the last is displayed. Load on the boundary edge -> shown in that frame.
- Leading-zero blank: i_lz_blank=1 with 0x0050 -> sel3 and sel2 have en=0, sel1 shows 5, sel0 shows 0 with en=1. With 0x0000 -> only digit 0 is lit. With 0x0A00 and i_dp=4'b1000 -> digit 3 blanked with o_dp=0; digit 2 shows A.
- Disable mid-scan: drop i_en during sel2 -> next edge en=0, sel=0. Reassert -> sel0 for a full 4 cycles.
- Reset mid-operation: assert i_reset during BLANK of digit 1 with pending_valid=1 -> outputs zero on the next edge and pending data discarded; after release the display shows 0 until the next i_load.
